// File: rtl/bcd_pkg.sv
// bcd_pkg: shared constants, state encoding and digit helper for the BCD-to-binary converter
// Contents:
//   DIGIT_W     width of one BCD digit
//   ADJ_THRESH  digit value at or above which the reverse double-dabble adjust applies
//   ADJ_VAL     amount subtracted from a digit that needs adjusting
//   state_t     converter state encoding (IDLE, SHIFT)
//   digit_invalid() returns 1 for a 4-bit code that is not a decimal digit
package bcd_pkg;

    localparam int DIGIT_W = 4;
    localparam logic [DIGIT_W-1:0] ADJ_THRESH = 4'd8;
    localparam logic [DIGIT_W-1:0] ADJ_VAL    = 4'd3;

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    function automatic logic digit_invalid(input logic [DIGIT_W-1:0] d);
        return d > 4'd9;
    endfunction

endpackage

// File: rtl/bcd_digit_adj.sv
// bcd_digit_adj: reverse double-dabble digit correction (subtract 3 when digit >= 8)
// Ports:
//   d  input  4  digit after the right shift
//   q  output 4  corrected digit
module bcd_digit_adj
    import bcd_pkg::*;
(
    input  logic [DIGIT_W-1:0] d,
    output logic [DIGIT_W-1:0] q
);

    assign q = (d >= ADJ_THRESH) ? d - ADJ_VAL : d;

endmodule

// File: rtl/bcd2bin_16_seq.sv
// bcd2bin_16_seq: sequential BCD-to-binary converter, one reverse double-dabble shift per cycle
// Ports:
//   clk        input  1  rising-edge clock
//   reset      input  1  synchronous active-high reset
//   start      input  1  request conversion of bcdIn, sampled only in IDLE
//   bcdIn      input  W  {sign, BCD digits}, most significant digit highest
//   busy       output 1  high while a conversion is in progress
//   done       output 1  one-cycle pulse when binaryOut has just been updated
//   binaryOut  output W  {sign, binary magnitude}, held until next completion or reset
//   digitErr   output 1  captured input held a digit > 9 (tied 0 unless enabled)
// Build option: define BCD2BIN_DIGIT_CHECK_EN to enable the invalid-digit flag.
module bcd2bin_16_seq
    import bcd_pkg::*;
#(
    parameter  int N_DIGITS = 4,
    localparam int W        = 4 * N_DIGITS + 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [W-1:0] bcdIn,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] binaryOut,
    output logic         digitErr
);

    localparam int BW = DIGIT_W * N_DIGITS;
    localparam int CW = $clog2(BW);

    state_t          state;
    logic [CW-1:0]   cnt;
    logic            sign;
    logic [BW-1:0]   bcd_reg;
    logic [BW-1:0]   bin_acc;
    logic [BW-1:0]   sh_bcd;
    logic [BW-1:0]   sh_bin;
    logic [BW-1:0]   adj_bcd;

    // {bcd_reg, bin_acc} shifted right as one long register
    assign sh_bcd = {1'b0, bcd_reg[BW-1:1]};
    assign sh_bin = {bcd_reg[0], bin_acc[BW-1:1]};

    for (genvar i = 0; i < N_DIGITS; i++) begin : g_adj
        bcd_digit_adj u_adj (
            .d(sh_bcd[i*DIGIT_W +: DIGIT_W]),
            .q(adj_bcd[i*DIGIT_W +: DIGIT_W])
        );
    end

`ifdef BCD2BIN_DIGIT_CHECK_EN
    logic err_flag;
    logic bad_in;

    always_comb begin
        bad_in = 1'b0;
        for (int i = 0; i < N_DIGITS; i++)
            bad_in = bad_in | digit_invalid(bcdIn[i*DIGIT_W +: DIGIT_W]);
    end
`else
    assign digitErr = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= '0;
            sign      <= 1'b0;
            bcd_reg   <= '0;
            bin_acc   <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            binaryOut <= '0;
`ifdef BCD2BIN_DIGIT_CHECK_EN
            err_flag  <= 1'b0;
            digitErr  <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            if (state == IDLE) begin
                if (start) begin
                    sign     <= bcdIn[W-1];
                    bcd_reg  <= bcdIn[W-2:0];
                    bin_acc  <= '0;
                    cnt      <= CW'(BW - 1);
                    busy     <= 1'b1;
                    state    <= SHIFT;
`ifdef BCD2BIN_DIGIT_CHECK_EN
                    err_flag <= bad_in;
`endif
                end
            end else begin
                bcd_reg <= adj_bcd;
                bin_acc <= sh_bin;
                cnt     <= cnt - 1'b1;
                // last shift completes the magnitude; publish it on the same edge
                if (cnt == '0) begin
                    binaryOut <= {sign, sh_bin};
                    done      <= 1'b1;
                    busy      <= 1'b0;
                    state     <= IDLE;
`ifdef BCD2BIN_DIGIT_CHECK_EN
                    digitErr  <= err_flag;
`endif
                end
            end
        end
    end

endmodule

// File: tb/tb_bcd2bin_16_seq.sv
// tb_bcd2bin_16_seq: randomized self-checking bench for bcd2bin_16_seq against a decimal model
module tb_bcd2bin_16_seq;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [16:0] bcdIn = '0;
    logic        busy;
    logic        done;
    logic [16:0] binaryOut;
    logic        digitErr;

    int checks = 0;
    int failures = 0;

    bcd2bin_16_seq dut (
        .clk(clk),
        .reset(reset),
        .start(start),
        .bcdIn(bcdIn),
        .busy(busy),
        .done(done),
        .binaryOut(binaryOut),
        .digitErr(digitErr)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // decimal value of the four digits, sign carried alongside
    function automatic logic [16:0] ref_bin(input logic [16:0] v);
        int mag = 0;
        for (int i = 3; i >= 0; i--)
            mag = mag * 10 + int'((v >> (4 * i)) & 17'hF);
        return {v[16], 16'(mag)};
    endfunction

    function automatic logic [16:0] rand_bcd();
        logic [16:0] v;
        v[16] = 1'($urandom_range(0, 1));
        for (int i = 0; i < 4; i++)
            v[4*i +: 4] = 4'($urandom_range(0, 9));
        return v;
    endfunction

    // called #1 after a rising edge with the DUT idle
    task automatic convert(input logic [16:0] v, output logic [16:0] r, output int lat, output int bcyc);
        bcdIn = v;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        bcdIn = 17'($urandom);
        lat = 0;
        bcyc = busy ? 1 : 0;
        while (!done && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
            if (busy) bcyc++;
        end
        r = binaryOut;
    endtask

    task automatic run_one(input string tag, input logic [16:0] v, input logic [16:0] exp);
        logic [16:0] r;
        int lat, bcyc;
        convert(v, r, lat, bcyc);
        check({tag, "_latency"}, lat, 16);
        check({tag, "_busy_cycles"}, bcyc, 16);
        check({tag, "_result"}, r, exp);
        check({tag, "_busy_at_done"}, busy, 0);
        @(posedge clk);
        #1;
        check({tag, "_done_one_cycle"}, done, 0);
        check({tag, "_hold"}, binaryOut, exp);
    endtask

    initial begin
        logic [16:0] v;
        int n, d1, d2, nd;

        repeat (2) @(posedge clk);
        #1;
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_out", binaryOut, 0);
        check("reset_err", digitErr, 0);
        reset = 1'b0;
        @(posedge clk);
        #1;

        run_one("max", 17'h09999, 17'h0270F);
        run_one("neg1234", 17'h11234, 17'h104D2);
        run_one("zero", 17'h00000, 17'h00000);
        run_one("negzero", 17'h10000, 17'h10000);

        for (int i = 0; i < 24; i++) begin
            v = rand_bcd();
            run_one($sformatf("rand%0d", i), v, ref_bin(v));
        end
        check("err_default_clear", digitErr, 0);

        // back-to-back with start held through done
        bcdIn = 17'h00042;
        start = 1'b1;
        @(posedge clk);
        #1;
        bcdIn = 17'h00100;
        n = 0; d1 = -1; d2 = -1;
        while (n < 60 && d2 < 0) begin
            @(posedge clk);
            #1;
            n++;
            if (done) begin
                if (d1 < 0) begin
                    d1 = n;
                    check("b2b_first", binaryOut, 17'h0002A);
                end else begin
                    d2 = n;
                    check("b2b_second", binaryOut, 17'h00064);
                end
            end
        end
        start = 1'b0;
        check("b2b_first_latency", d1, 16);
        check("b2b_gap", d2 - d1, 17);
        repeat (2) @(posedge clk);
        #1;
        check("b2b_idle", busy, 0);

        // start pulse mid-conversion is ignored
        bcdIn = 17'h01234;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        n = 0; nd = 0; d1 = -1;
        while (n < 40) begin
            if (n == 5) begin
                bcdIn = 17'h00500;
                start = 1'b1;
            end else start = 1'b0;
            @(posedge clk);
            #1;
            n++;
            if (done) begin
                nd++;
                if (d1 < 0) begin
                    d1 = n;
                    check("ignore_result", binaryOut, 17'h004D2);
                end
            end
        end
        start = 1'b0;
        check("ignore_done_count", nd, 1);
        check("ignore_latency", d1, 16);

        // reset aborts a conversion
        bcdIn = 17'h05555;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        check("abort_busy", busy, 0);
        check("abort_out", binaryOut, 0);
        nd = 0;
        for (int i = 0; i < 25; i++) begin
            @(posedge clk);
            #1;
            if (done) nd++;
        end
        check("abort_no_done", nd, 0);
        check("abort_out_held", binaryOut, 0);
        run_one("after_abort", 17'h00007, 17'h00007);

`ifdef BCD2BIN_DIGIT_CHECK_EN
        begin
            logic [16:0] r;
            int lat, bcyc;
            convert(17'h000A5, r, lat, bcyc);
            check("digit_err_set", digitErr, 1);
            check("digit_err_latency", lat, 16);
            @(posedge clk);
            #1;
            check("digit_err_held", digitErr, 1);
            convert(17'h00095, r, lat, bcyc);
            check("digit_err_clear", digitErr, 0);
            check("digit_ok_result", r, 17'h0005F);
        end
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
